// File: rtl/obi_mem_responder.sv
// obi_mem_responder: memory-side responder for one OBI-style port.
// It turns free solver inputs into grant/rvalid/rdata/err sequences that obey the bus protocol.
// It keeps at most MAX_OUTSTANDING transactions granted but not yet answered.
// It also raises a sticky flag when the core breaks the request protocol.
//
// Optional feature macro: OBI_RESP_FAIRNESS_EN.
// When defined, stall and age counters force a grant or a response after a bounded wait.
// When undefined, every grant and response is chosen by the solver inputs alone.
//
// Handshake: a request transfers on a cycle with req_i && gnt_o.
// Each transfer gets exactly one rvalid_o pulse, in order, at least one cycle later.
// The core must hold req_i and every request field stable from the first cycle of a
// request until that request is granted.
module obi_mem_responder #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_STALL       = 4,
    parameter int MAX_LATENCY     = 4,
    parameter int ERR_EN          = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        rand_gnt_i,
    input  logic        rand_rvalid_i,
    input  logic [31:0] rand_rdata_i,
    input  logic        rand_err_i,
    output logic [2:0]  outstanding_o,
    output logic        violation_o
);

    // Parameter range guards, evaluated at elaboration time.
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_outstanding
        $error("obi_mem_responder: MAX_OUTSTANDING must be 1..4");
    end
    if (MAX_STALL < 1) begin : g_bad_stall
        $error("obi_mem_responder: MAX_STALL must be >= 1");
    end
    if (MAX_LATENCY < 1) begin : g_bad_latency
        $error("obi_mem_responder: MAX_LATENCY must be >= 1");
    end

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    logic [2:0]  count_q, count_d;
    logic        pend_q, pend_d;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic        viol_q, viol_d;
    logic        resp_ok;
    logic        force_gnt;
    logic        force_rvalid;

    // count_q only holds transactions granted in earlier cycles.
    // A grant in this cycle therefore cannot be answered in the same cycle.
    assign resp_ok = (count_q != 3'd0);

    // rst_ni gates the combinational outputs, so they stay quiet while reset is held.
    assign gnt_o    = rst_ni && req_i && (count_q < MAX_CNT) && (rand_gnt_i || force_gnt);
    assign rvalid_o = rst_ni && resp_ok && (rand_rvalid_i || force_rvalid);
    assign rdata_o  = rvalid_o ? rand_rdata_i : 32'h0;
    assign err_o    = (ERR_EN != 0) && rvalid_o && rand_err_i;

    assign outstanding_o = count_q;
    assign violation_o   = viol_q;

    // The outstanding count cannot wrap.
    // Grant is blocked at MAX_CNT and rvalid is blocked at zero.
    assign count_d = count_q + {2'b00, gnt_o} - {2'b00, rvalid_o};

    // A request still pending is one seen this cycle but not granted.
    // Dropping req_i also clears it.
    assign pend_d = req_i && !gnt_o;

    // Sticky violation flag.
    // It sets when a pending request drops or changes, or on a write with no byte enabled.
    always_comb begin
        viol_d = viol_q;
        if (pend_q && (!req_i || addr_i != addr_q || we_i != we_q ||
                       be_i != be_q || wdata_i != wdata_q)) begin
            viol_d = 1'b1;
        end
        if (req_i && we_i && (be_i == 4'h0)) begin
            viol_d = 1'b1;
        end
    end

    // Outstanding count, pending flag and violation flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 3'd0;
            pend_q  <= 1'b0;
            viol_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            pend_q  <= pend_d;
            viol_q  <= viol_d;
        end
    end

    // Capture the request fields while the request waits for a grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
        end else if (pend_d) begin
            addr_q  <= addr_i;
            we_q    <= we_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
        end
    end

`ifdef OBI_RESP_FAIRNESS_EN
    localparam logic [7:0] STALL_LIM = 8'(MAX_STALL - 1);
    localparam logic [7:0] AGE_LIM   = 8'(MAX_LATENCY - 1);

    logic [7:0] stall_q;
    logic [7:0] age_q;

    assign force_gnt    = (stall_q >= STALL_LIM);
    assign force_rvalid = (age_q >= AGE_LIM) && resp_ok;

    // Count the cycles a request has waited for its grant.
    // The counter saturates at its top value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= 8'd0;
        end else if (req_i && !gnt_o) begin
            if (stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
        end else begin
            stall_q <= 8'd0;
        end
    end

    // Age of the oldest outstanding transaction.
    // It restarts when a response retires the oldest one.
    // It stays at zero while nothing is outstanding, so a 0->1 count change starts it from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q <= 8'd0;
        end else if (rvalid_o || !resp_ok) begin
            age_q <= 8'd0;
        end else if (age_q != 8'hFF) begin
            age_q <= age_q + 8'd1;
        end
    end
`else
    assign force_gnt    = 1'b0;
    assign force_rvalid = 1'b0;
`endif

endmodule
